// File: rtl/pc_pkg.sv
// Shared types for the picoMIPS PC with return-address stack.
// Holds the per-cycle PC operation and the control priority resolver.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INCR,
        OP_REL,
        OP_ABS,
        OP_CALL,
        OP_RET
    } pc_op_t;

    // Exactly one action per cycle; lower-priority controls are dropped.
    function automatic pc_op_t pc_resolve(input logic stall, input logic ret,
                                          input logic call, input logic absb,
                                          input logic rel, input logic incr);
        pc_op_t op;
        op = OP_HOLD;
        if (stall)     op = OP_HOLD;
        else if (ret)  op = OP_RET;
        else if (call) op = OP_CALL;
        else if (absb) op = OP_ABS;
        else if (rel)  op = OP_REL;
        else if (incr) op = OP_INCR;
        return op;
    endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Decode-side control bundle and status outputs of the program counter.
interface pc_stack_if #(parameter int Psize = 8);
    logic             stall;
    logic             PCincr;
    logic             PCrelbranch;
    logic             PCabsbranch;
    logic             PCcall;
    logic             PCret;
    logic             err_clr;
    logic [Psize-1:0] Branchaddr;
    logic [Psize-1:0] PCout;
    logic             stack_full;
    logic             stack_empty;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output stall, PCincr, PCrelbranch, PCabsbranch, PCcall, PCret, err_clr, Branchaddr,
        input  PCout, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  stall, PCincr, PCrelbranch, PCabsbranch, PCcall, PCret, err_clr, Branchaddr,
        output PCout, stack_full, stack_empty, ovf_err, unf_err
    );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack as a circular buffer; a push while full overwrites
// the oldest entry so the most recent Depth return addresses survive.
module pc_ras #(
    parameter int Psize = 8,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Psize-1:0] din,
    output logic [Psize-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);

    logic [Psize-1:0] mem [Depth];
    logic [PW-1:0]    top;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    top_up;
    logic [PW-1:0]    top_dn;

    // Explicit wrap so non-power-of-two depths stay inside the array.
    assign top_up = (top == PW'(Depth - 1)) ? '0 : top + 1'b1;
    assign top_dn = (top == '0) ? PW'(Depth - 1) : top - 1'b1;

    assign full  = (cnt == CW'(Depth));
    assign empty = (cnt == '0);
    assign dout  = mem[top];
    assign drop  = push & full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top <= '0;
            cnt <= '0;
        end else if (push) begin
            top <= top_up;
            if (!full) cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            top <= top_dn;
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[top_up] <= din;
    end

endmodule

// File: rtl/pc_stack.sv
// picoMIPS program counter: increment, absolute/relative branch, call/return
// through a return-address stack, with sticky overflow/underflow flags.
module pc_stack
    import pc_pkg::*;
#(
    parameter int Psize = 8,
    parameter int Depth = 4
) (
    input  logic        clk,
    input  logic        reset,
    pc_stack_if.slave   bus
);
    pc_op_t           op;
    logic [Psize-1:0] pc;
    logic [Psize-1:0] pc_nxt;
    logic [Psize-1:0] addend;
    logic [Psize-1:0] sum;
    logic [Psize-1:0] ras_top;
    logic             ras_full;
    logic             ras_empty;
    logic             ras_drop;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             unf_set;
    logic             ovf_q;
    logic             unf_q;

    assign op = pc_resolve(bus.stall, bus.PCret, bus.PCcall, bus.PCabsbranch,
                           bus.PCrelbranch, bus.PCincr);

    // One adder serves increment, relative branch, call return address and
    // the empty-return NOP.
    always_comb begin
        addend = Psize'(1);
        if (op == OP_REL) addend = bus.Branchaddr;
    end
    assign sum = pc + addend;

    always_comb begin
        pc_nxt = pc;
        case (op)
            OP_INCR, OP_REL: pc_nxt = sum;
            OP_ABS, OP_CALL: pc_nxt = bus.Branchaddr;
            OP_RET:          pc_nxt = ras_empty ? sum : ras_top;
            default:         pc_nxt = pc;
        endcase
    end

    assign push    = (op == OP_CALL);
    assign pop     = (op == OP_RET) && !ras_empty;
    assign ovf_set = ras_drop;
    assign unf_set = (op == OP_RET) && ras_empty;

    pc_ras #(.Psize(Psize), .Depth(Depth)) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (sum),
        .dout  (ras_top),
        .full  (ras_full),
        .empty (ras_empty),
        .drop  (ras_drop)
    );

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc    <= pc_nxt;
            ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
            unf_q <= unf_set | (unf_q & ~bus.err_clr);
        end
    end

    assign bus.PCout       = pc;
    assign bus.stack_full  = ras_full;
    assign bus.stack_empty = ras_empty;
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed-vector bench for pc_stack (Psize=8, Depth=4): table of single-cycle
// vectors plus hand-written sequences for async reset and flag clearing.
module tb_pc_stack;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pc_stack_if #(.Psize(8)) bus ();

    pc_stack #(.Psize(8), .Depth(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       stall, incr, rel, absb, call, ret, clr;
        logic [7:0] ba;
        logic [7:0] pc;
        logic       full, empty, ovf, unf;
    } vec_t;

    vec_t tv[$];
    int   n_chk = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic stall, incr, rel, absb, call, ret, clr,
                                input logic [7:0] ba, input logic [7:0] pc,
                                input logic full, empty, ovf, unf);
        vec_t v;
        v.stall = stall; v.incr = incr; v.rel = rel; v.absb = absb;
        v.call = call; v.ret = ret; v.clr = clr; v.ba = ba; v.pc = pc;
        v.full = full; v.empty = empty; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic stall, incr, rel, absb, call, ret, clr,
                         input logic [7:0] ba);
        bus.stall = stall; bus.PCincr = incr; bus.PCrelbranch = rel;
        bus.PCabsbranch = absb; bus.PCcall = call; bus.PCret = ret;
        bus.err_clr = clr; bus.Branchaddr = ba;
    endtask

    task automatic step(input logic stall, incr, rel, absb, call, ret, clr,
                        input logic [7:0] ba);
        drive(stall, incr, rel, absb, call, ret, clr, ba);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [7:0] pc,
                           input logic full, empty, ovf, unf);
        chk({nm, " pc"},    bus.PCout, pc);
        chk({nm, " full"},  {7'b0, bus.stack_full},  {7'b0, full});
        chk({nm, " empty"}, {7'b0, bus.stack_empty}, {7'b0, empty});
        chk({nm, " ovf"},   {7'b0, bus.ovf_err},     {7'b0, ovf});
        chk({nm, " unf"},   {7'b0, bus.unf_err},     {7'b0, unf});
    endtask

    initial begin
        // stall incr rel abs call ret clr | ba | pc full empty ovf unf
        for (int k = 1; k <= 5; k++)
            tv.push_back(mk(0,1,0,0,0,0,0, 8'h00, 8'(k), 0,1,0,0));
        tv.push_back(mk(0,0,0,1,0,0,0, 8'hFF, 8'hFF, 0,1,0,0));
        tv.push_back(mk(0,1,0,0,0,0,0, 8'h00, 8'h00, 0,1,0,0)); // wrap
        tv.push_back(mk(0,0,0,1,0,0,0, 8'h10, 8'h10, 0,1,0,0));
        tv.push_back(mk(0,0,1,0,0,0,0, 8'hFE, 8'h0E, 0,1,0,0)); // -2
        tv.push_back(mk(0,0,0,1,0,0,0, 8'h10, 8'h10, 0,1,0,0));
        tv.push_back(mk(0,0,1,0,0,0,0, 8'h05, 8'h15, 0,1,0,0));
        tv.push_back(mk(0,0,0,1,0,0,0, 8'h20, 8'h20, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,1,0,0, 8'h40, 8'h40, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,1,0, 8'h00, 8'h21, 0,1,0,0));
        tv.push_back(mk(0,0,0,1,0,0,0, 8'h00, 8'h00, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,1,0,0, 8'h01, 8'h01, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,1,0,0, 8'h02, 8'h02, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,1,0,0, 8'h03, 8'h03, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,1,0,0, 8'h04, 8'h04, 1,0,0,0));
        tv.push_back(mk(0,0,0,0,1,0,0, 8'h05, 8'h05, 1,0,1,0)); // overwrite oldest
        tv.push_back(mk(0,0,0,0,0,1,0, 8'h00, 8'h05, 0,0,1,0));
        tv.push_back(mk(0,0,0,0,0,1,0, 8'h00, 8'h04, 0,0,1,0));
        tv.push_back(mk(0,0,0,0,0,1,0, 8'h00, 8'h03, 0,0,1,0));
        tv.push_back(mk(0,0,0,0,0,1,0, 8'h00, 8'h02, 0,1,1,0));
        tv.push_back(mk(0,0,0,0,0,1,0, 8'h00, 8'h03, 0,1,1,1)); // empty return
        tv.push_back(mk(0,0,0,0,0,0,1, 8'h00, 8'h03, 0,1,0,0));
        tv.push_back(mk(0,1,0,0,0,0,0, 8'h00, 8'h04, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,1,0,0, 8'h80, 8'h80, 0,0,0,0));
        for (int k = 0; k < 3; k++)
            tv.push_back(mk(1,1,0,0,1,0,0, 8'h90, 8'h80, 0,0,0,0));
        tv.push_back(mk(0,1,1,1,1,1,0, 8'h90, 8'h05, 0,1,0,0)); // only ret
        tv.push_back(mk(0,0,0,0,0,1,1, 8'h00, 8'h06, 0,1,0,1)); // set beats clear
        tv.push_back(mk(0,0,0,0,0,0,1, 8'h00, 8'h06, 0,1,0,0));
        tv.push_back(mk(0,0,0,1,0,0,0, 8'hFF, 8'hFF, 0,1,0,0));
        tv.push_back(mk(0,0,0,0,1,0,0, 8'h10, 8'h10, 0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,1,0, 8'h00, 8'h00, 0,1,0,0)); // pushed FF+1
        tv.push_back(mk(0,0,1,0,0,0,0, 8'h80, 8'h80, 0,1,0,0)); // -128

        drive(0,1,0,0,1,0,0, 8'h55);
        #7;
        chk_all("reset", 8'h00, 0,1,0,0);
        @(posedge clk);
        #1;
        chk_all("reset held", 8'h00, 0,1,0,0);
        reset = 1'b1;

        chk_all("start", 8'h00, 0,1,0,0);
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].stall, tv[i].incr, tv[i].rel, tv[i].absb, tv[i].call,
                 tv[i].ret, tv[i].clr, tv[i].ba);
            chk_all($sformatf("v%0d", i), tv[i].pc, tv[i].full, tv[i].empty,
                    tv[i].ovf, tv[i].unf);
        end

        // Fill past capacity, unwind two: 2 entries left with ovf set.
        for (int k = 0; k < 5; k++) step(0,0,0,0,1,0,0, 8'(8'h30 + k));
        step(0,0,0,0,0,1,0, 8'h00);
        step(0,0,0,0,0,1,0, 8'h00);
        chk_all("pre-reset", 8'h33, 0,0,1,0);
        drive(0,1,0,0,1,0,0, 8'h77);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async reset", 8'h00, 0,1,0,0);
        @(posedge clk);
        #1;
        chk_all("reset edge", 8'h00, 0,1,0,0);
        drive(0,0,0,0,0,0,0, 8'h00);
        reset = 1'b1;

        // err_clr honoured during stall, and on an idle cycle.
        step(0,0,0,0,0,1,0, 8'h00);
        chk_all("unf set", 8'h01, 0,1,0,1);
        step(1,1,0,0,0,0,1, 8'h00);
        chk_all("stall clr", 8'h01, 0,1,0,0);
        step(0,0,0,0,0,1,0, 8'h00);
        chk_all("unf again", 8'h02, 0,1,0,1);
        step(0,0,0,0,0,0,1, 8'h00);
        chk_all("idle clr", 8'h02, 0,1,0,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised picoMIPS program counter, successor to the basic increment/branch PC.
- Adds signed relative branches, a stall input, and subroutine call/return through a hardware return-address stack (RAS) of configurable depth, with full/empty status and sticky error flags.
- Sits between instruction decode and program memory address; PCout drives the program ROM address directly.

Parameters:
- Psize, 8, PC/address width in bits (up to 2^Psize instructions).
- Depth, 4, RAS entries (≥2, power of two not required).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  freeze PC and stack this cycle.
- PCincr  input  1  PC <= PC + 1.
- PCrelbranch  input  1  PC <= PC + signed(Branchaddr).
- PCabsbranch  input  1  PC <= Branchaddr.
- PCcall  input  1  push PC+1, PC <= Branchaddr.
- PCret  input  1  PC <= popped return address.
- err_clr  input  1  synchronous clear of sticky error flags.
- Branchaddr  input  Psize  target address or two's-complement offset.
- PCout  output  Psize  current PC.
- stack_full  output  1  RAS holds Depth entries.
- stack_empty  output  1  RAS holds 0 entries.
- ovf_err  output  1  sticky: call issued while full.
- unf_err  output  1  sticky: return issued while empty.

Behaviour:
- Reset (async, reset=0):
  - PCout=0, RAS count=0.
  - stack_empty=1, stack_full=0, ovf_err=0, unf_err=0.
  - RAS contents do not matter.
- Clocked update: all state changes on the rising clk edge. PCout is registered; a new value is visible one cycle after the control is sampled.
- Priority, one action per cycle:
  - stall > PCret > PCcall > PCabsbranch > PCrelbranch > PCincr > hold.
  - Lower-priority controls asserted in the same cycle are ignored.
- stall=1:
  - PCout, RAS and flags hold.
  - err_clr is still honoured.
- Arithmetic:
  - Increment and relative-branch addition use one Psize-bit adder.
  - Results wrap modulo 2^Psize; no overflow detection.
  - Relative offset is Branchaddr interpreted as signed, e.g. Psize=8: 8'hFE = -2.
- PCcall:
  - Pushes (PCout+1) mod 2^Psize and loads PCout <= Branchaddr.
  - If full: the oldest entry is discarded (circular overwrite), the new entry becomes top, count stays Depth, ovf_err <= 1. The jump still happens.
- PCret:
  - If not empty: PCout <= top entry, count decrements.
  - If empty: PCout <= PCout+1 (treated as NOP), count stays 0, unf_err <= 1.
- stack_full / stack_empty: derived from the registered count and valid in the same cycle as count.
- err_clr=1: ovf_err and unf_err <= 0, unless the same cycle sets them; set wins over clear.
- Reset asserted mid-operation: immediate return to reset state regardless of pending controls.

Decomposition:
- Shared package pc_pkg:
  - typedef enum pc_op_t {OP_HOLD, OP_INCR, OP_REL, OP_ABS, OP_CALL, OP_RET}.
  - Function that resolves control inputs to pc_op_t by the priority above.
- Sub-module pc_ras:
  - Parameters Psize, Depth.
  - Ports: clk, reset, push, pop, din, dout (top, combinational), full, empty, overflow-drop behaviour.
  - Implemented as a circular buffer with top pointer and count.
- pc_stack: holds the PC register, the adder/mux, and the error flags.

Test Plan (Psize=8, Depth=4):
- Reset, then PCincr for 5 cycles -> PCout 0,1,2,3,4,5. With PCout=8'hFF, one PCincr -> PCout=8'h00.
- PCout=8'h10, PCrelbranch with Branchaddr=8'hFE -> PCout=8'h0E; with Branchaddr=8'h05 -> PCout=8'h15.
- PCout=8'h20, PCcall to 8'h40 -> PCout=8'h40, stack_empty=0; then PCret -> PCout=8'h21, stack_empty=1.
- Nested calls from 8'h00,8'h01,8'h02,8'h03,8'h04 (5 calls) -> stack_full=1, ovf_err=1. Five PCret -> 8'h05,8'h04,8'h03,8'h02, then empty-return -> PCout+1, unf_err=1.
- stall held 3 cycles with PCincr and PCcall asserted -> PCout and stack unchanged. Simultaneous PCret+PCcall+PCincr -> only return executes.
- Assert reset mid-sequence with 2 stack entries and ovf_err=1 -> PCout=0, stack_empty=1, flags 0 asynchronously. err_clr with no new error -> flags cleared next edge.
